booth_product_accumulator: RTL
==============================

Name: booth_product_accumulator

Overview:
- Sequential stage directly downstream of the 4x4 signed Booth multiplier. It consumes the multiplier's 8-bit signed PRODUCT values through a valid/ready handshake.
- Sums a programmed number of products into a wider signed accumulator, then presents the total on a held output handshake.
- Forms the accumulate half of a dot-product / MAC datapath.

Parameters:
- PROD_W, 8, width of the signed product input; matches the multiplier output.
- ACC_W, 12, width of the signed accumulator and result. Must satisfy ACC_W >= PROD_W.
- LEN_W, 4, width of the run-length field. One run holds at most 2^LEN_W-1 products.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse that begins a run. Sampled only in IDLE.
- len  in  LEN_W  number of products in the run. Captured when start is accepted.
- in_valid  in  1  in_product is valid.
- in_ready  out  1  block accepts a product this cycle.
- in_product  in  PROD_W  signed product (two's complement).
- out_valid  out  1  result is available.
- out_ready  in  1  consumer takes the result.
- out_sum  out  ACC_W  signed accumulated result.
- out_ovf  out  1  sticky flag: at least one add in this run overflowed ACC_W.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State=IDLE; accumulator=0; counter=0.
  - out_sum=0, out_ovf=0, out_valid=0, in_ready=0, busy=0.
  - Reset mid-run abandons the run with no partial output.
- States are IDLE, ACCUM, DONE. All outputs are registered or decoded from state; there is no combinational path from in_valid or out_ready to any output.
- IDLE:
  - If start=1 and len!=0: clear acc and ovf, load count=len, go to ACCUM.
  - If start=1 and len==0: clear acc and ovf, go to DONE, so out_valid=1 the next cycle with out_sum=0.
  - Otherwise stay in IDLE.
- ACCUM:
  - in_ready=1.
  - On in_valid&&in_ready: acc <= acc + sign_extend(in_product); count <= count-1.
  - When the accepted product is the last one (count==1), go to DONE.
  - When in_valid=0, hold all state; there is no timeout.
- DONE:
  - out_valid=1; out_sum=acc; out_ovf=sticky flag; in_ready=0.
  - out_sum and out_ovf stay stable while out_valid=1 and out_ready=0.
  - On out_ready=1, go to IDLE. out_valid drops the following cycle.
- Latency: out_valid rises the cycle after the last product handshake. Throughput is one product per cycle.
- start outside IDLE is ignored, including the same cycle as the DONE->IDLE transition. A new start is accepted one cycle later, in IDLE.
- Arithmetic:
  - Sign-extend the product to ACC_W bits.
  - Overflow = both operands have equal sign and the sum's sign differs.
  - Default: result wraps modulo 2^ACC_W; out_ovf is set and stays set until the next start.

Optional Feature:
- Macro: BOOTH_ACC_SATURATE_EN.
- Defined: an overflowing add clamps acc to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)), according to the operand sign. out_ovf is still set.
- Undefined: two's-complement wrap as described under Behaviour.
- Handshake timing is identical in both builds.

Decomposition:
- Shared package booth_pkg holds:
  - PROD_W and default ACC_W/LEN_W constants.
  - State enum acc_state_t {IDLE, ACCUM, DONE}.
  - A sign-extend helper function.
- One natural sub-module: booth_sat_add (ACC_W-wide signed add that returns sum and overflow). It contains the BOOTH_ACC_SATURATE_EN clamp logic; the top-level holds the FSM, counter and handshake.

Test Plan:
- Basic run: len=4; products 3, -5, 7, -1 presented back-to-back -> out_valid one cycle after the 4th handshake; out_sum=4; out_ovf=0.
- Zero length: start with len=0 -> in_ready never asserts; out_valid=1 next cycle; out_sum=0; out_ovf=0.
- Input and output stalls:
  - len=3, products -8, -8, -8 with in_valid gaps of 2 cycles -> out_sum=-24.
  - Hold out_ready=0 for 5 cycles -> out_valid and out_sum stay stable; busy=1 throughout.
- Overflow, ACC_W=8, len=2, products 127, 127:
  - Default build -> out_sum=-2, out_ovf=1.
  - With BOOTH_ACC_SATURATE_EN -> out_sum=127, out_ovf=1.
- Ignored start: start pulse with len=7 during ACCUM of a len=2 run (products 10, 20) -> out_sum=30; the run still ends after 2 products.
- Reset mid-run: drop rst_n after 1 of 3 products -> all outputs 0 immediately (asynchronous). A new run len=1, product -100 -> out_sum=-100, out_ovf=0.

Source files
------------

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared constants, state encoding and sign-extend helper for the product accumulator
package booth_pkg;

  localparam int BOOTH_PROD_W = 8;
  localparam int BOOTH_ACC_W  = 12;
  localparam int BOOTH_LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

  // Widen a signed product to 32 bits; callers narrow it to their accumulator width.
  function automatic logic signed [31:0] sext_prod(input logic [BOOTH_PROD_W-1:0] p);
    return 32'($signed(p));
  endfunction

endpackage

// File: rtl/booth_sat_add.sv
// rtl/booth_sat_add.sv - signed W-bit adder with overflow flag; clamps when BOOTH_ACC_SATURATE_EN is defined
module booth_sat_add #(
  parameter int W = 12
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  logic [W-1:0] raw_sum;

  // Overflow when both operands share a sign and the wrapped sum does not.
  always_comb begin
    raw_sum = a_i + b_i;
    ovf_o   = (a_i[W-1] == b_i[W-1]) && (raw_sum[W-1] != a_i[W-1]);
`ifdef BOOTH_ACC_SATURATE_EN
    if (ovf_o) begin
      sum_o = a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sum_o = raw_sum;
    end
`else
    sum_o = raw_sum;
`endif
  end

endmodule

// File: rtl/booth_product_accumulator.sv
// rtl/booth_product_accumulator.sv - sums a run of signed products and holds the total on a valid/ready output (option: BOOTH_ACC_SATURATE_EN)
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int PROD_W = BOOTH_PROD_W,
  parameter int ACC_W  = BOOTH_ACC_W,
  parameter int LEN_W  = BOOTH_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;

  assign prod_ext = ACC_W'(sext_prod(in_product));

  booth_sat_add #(
    .W (ACC_W)
  ) u_add (
    .a_i   (acc_q),
    .b_i   (prod_ext),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  // Outputs come only from registered state so no input reaches an output combinationally.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

  // Next-state: start a run, accumulate each accepted product, release on out_ready.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            cnt_d   = len;
            state_d = ACCUM;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
